// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, ALU/mux selects,
// FSM states and the bundled datapath control word.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_RTYPE = 2'd2
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_REG     = 2'd0,
    SRCB_FOUR    = 2'd1,
    SRCB_IMM     = 2'd2,
    SRCB_IMM_SH2 = 2'd3
  } src_b_t;

  typedef enum logic [1:0] {
    PC_ALU    = 2'd0,
    PC_ALUOUT = 2'd1,
    PC_JUMP   = 2'd2
  } pc_src_t;

  // FETCH must stay at zero: the state port reads as zero while in reset.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_R_WB     = 4'd4,
    S_I_WB     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  typedef struct packed {
    logic    pc_write;
    logic    pc_write_cond;
    logic    ir_write;
    logic    i_or_d;
    logic    mem_read;
    logic    mem_write;
    logic    mem_2_reg;
    logic    reg_dst;
    logic    reg_write;
    logic    alu_src_a;
    src_b_t  alu_src_b;
    alu_op_t alu_op;
    pc_src_t pc_source;
    logic    instr_done;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Instruction-register/datapath-facing signal bundle of the multi-cycle controller.
interface multicycle_control_if #(
  parameter int unsigned STATE_W = 4
);
  logic [5:0]         opcode;
  logic               zero;
  logic               mem_ready;
  logic               pc_write;
  logic               pc_write_cond;
  logic               ir_write;
  logic               i_or_d;
  logic               mem_read;
  logic               mem_write;
  logic               mem_2_reg;
  logic               reg_dst;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         alu_op;
  logic [1:0]         pc_source;
  logic               instr_done;
  logic               illegal_op;
  logic [STATE_W-1:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
           mem_2_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
           mem_2_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op, state
  );
endinterface

// File: rtl/control_out_decode.sv
// Combinational map from (state, rdy) to the datapath control word.
module control_out_decode
  import mips_pkg::*;
(
  input  state_t state,
  input  logic   rdy,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = rdy;
        ctrl.pc_write  = rdy;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH2;
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_RTYPE;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_R_WB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = rdy;
        ctrl.instr_done = rdy;
      end
      S_I_WB: begin
        ctrl.reg_write  = rdy;
        ctrl.instr_done = rdy;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      // Load data is already captured; the register write does not wait on memory.
      S_MEM_WB: begin
        ctrl.mem_2_reg  = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = rdy;
      end
      S_MEM_WR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = rdy;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_ALUOUT;
        ctrl.instr_done    = rdy;
      end
      S_JUMP: begin
        ctrl.pc_write   = rdy;
        ctrl.pc_source  = PC_JUMP;
        ctrl.instr_done = rdy;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: state register, opcode latch and next-state dispatch;
// memory states stretch on mem_ready when MEM_HANDSHAKE is set.
module multicycle_control
  import mips_pkg::*;
#(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter int unsigned STATE_W       = 4
) (
  input logic                 clk,
  input logic                 rst,
  multicycle_control_if.master bus
);

  state_t     cur, nxt;
  logic [5:0] opc_q;
  logic       rdy;
  logic       illegal;
  ctrl_t      dec, ctl;

  assign rdy = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur   <= S_FETCH;
      opc_q <= '0;
    end else begin
      cur <= nxt;
      if (cur == S_DECODE) opc_q <= bus.opcode;
    end
  end

  always_comb begin
    nxt     = cur;
    illegal = 1'b0;
    case (cur)
      S_FETCH: if (rdy) nxt = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     nxt = S_EXEC_R;
          OP_ADDI:      nxt = S_EXEC_I;
          OP_LW, OP_SW: nxt = S_MEM_ADDR;
          OP_BEQ:       nxt = S_BRANCH;
          OP_J:         nxt = S_JUMP;
          default: begin
            nxt     = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_EXEC_R:   nxt = S_R_WB;
      S_EXEC_I:   nxt = S_I_WB;
      // The opcode port may already carry the next instruction here.
      S_MEM_ADDR: nxt = (opc_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (rdy) nxt = S_MEM_WB;
      S_MEM_WR:   if (rdy) nxt = S_FETCH;
      default:    nxt = S_FETCH;
    endcase
  end

  control_out_decode u_decode (
    .state (cur),
    .rdy   (rdy),
    .ctrl  (dec)
  );

  always_comb ctl = rst ? '0 : dec;

  assign bus.pc_write      = ctl.pc_write;
  assign bus.pc_write_cond = ctl.pc_write_cond;
  assign bus.ir_write      = ctl.ir_write;
  assign bus.i_or_d        = ctl.i_or_d;
  assign bus.mem_read      = ctl.mem_read;
  assign bus.mem_write     = ctl.mem_write;
  assign bus.mem_2_reg     = ctl.mem_2_reg;
  assign bus.reg_dst       = ctl.reg_dst;
  assign bus.reg_write     = ctl.reg_write;
  assign bus.alu_src_a     = ctl.alu_src_a;
  assign bus.alu_src_b     = ctl.alu_src_b;
  assign bus.alu_op        = ctl.alu_op;
  assign bus.pc_source     = ctl.pc_source;
  assign bus.instr_done    = ctl.instr_done;
  assign bus.illegal_op    = illegal & ~rst;
  assign bus.state         = rst ? '0 : STATE_W'(cur);

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: handshake instance plus a MEM_HANDSHAKE=0 instance.
module tb_multicycle_control;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  multicycle_control_if #(.STATE_W(4)) ifa ();
  multicycle_control_if #(.STATE_W(4)) ifb ();

  multicycle_control #(.MEM_HANDSHAKE(1'b1), .STATE_W(4)) dut_a (
    .clk (clk), .rst (rst_a), .bus (ifa.master)
  );
  multicycle_control #(.MEM_HANDSHAKE(1'b0), .STATE_W(4)) dut_b (
    .clk (clk), .rst (rst_b), .bus (ifb.master)
  );

  typedef struct packed {
    logic [3:0]  st;
    logic [17:0] ctl;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0, n_fail = 0;
  int cyc_n, done_at, n_irw, n_done, n_mrd, n_m2r, n_mw, n_wr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Control word {pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write, mem_2_reg,
  // reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, illegal_op}.
  function automatic logic [17:0] ref_ctl(state_t st, logic rdy, logic [5:0] op);
    logic pw = 0, pwc = 0, irw = 0, iord = 0, mrd = 0, mwr = 0, m2r = 0, rdst = 0, rw = 0, asa = 0;
    logic [1:0] b = 0, aop = 0, pcs = 0;
    logic done = 0, ill = 0;
    case (st)
      S_FETCH:    begin mrd = 1; b = 2'd1; irw = rdy; pw = rdy; end
      S_DECODE:   begin
        b = 2'd3;
        ill = !(op inside {6'h00, 6'h08, 6'h04, 6'h02, 6'h23, 6'h2B});
      end
      S_EXEC_R:   begin asa = 1; b = 2'd0; aop = 2'd2; end
      S_EXEC_I:   begin asa = 1; b = 2'd2; end
      S_MEM_ADDR: begin asa = 1; b = 2'd2; end
      S_R_WB:     begin rdst = 1; rw = rdy; done = rdy; end
      S_I_WB:     begin rw = rdy; done = rdy; end
      S_MEM_RD:   begin mrd = 1; iord = 1; end
      S_MEM_WB:   begin m2r = 1; rw = 1; done = rdy; end
      S_MEM_WR:   begin mwr = 1; iord = 1; done = rdy; end
      S_BRANCH:   begin asa = 1; aop = 2'd1; pwc = 1; pcs = 2'd1; done = rdy; end
      S_JUMP:     begin pw = rdy; pcs = 2'd2; done = rdy; end
      default: ;
    endcase
    return {pw, pwc, irw, iord, mrd, mwr, m2r, rdst, rw, asa, b, aop, pcs, done, ill};
  endfunction

  task automatic clr();
    cyc_n = 0; done_at = -1; n_irw = 0; n_done = 0; n_mrd = 0; n_m2r = 0; n_mw = 0; n_wr = 0;
  endtask

  // One clock cycle: drive inputs, push expectation, compare at the falling edge.
  task automatic cyc(input bit sel, input logic r, input logic [5:0] op, input logic mr,
                     input logic z, input state_t est);
    exp_t e, g;
    logic [17:0] oc;
    logic [3:0] os;
    if (!sel) begin
      ifa.opcode = op; ifa.mem_ready = mr; ifa.zero = z; rst_a = r;
    end else begin
      ifb.opcode = op; ifb.zero = z; rst_b = r;
    end
    e.st  = r ? 4'd0 : 4'(est);
    e.ctl = r ? '0 : ref_ctl(est, sel ? 1'b1 : mr, op);
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    if (!sel) begin
      os = ifa.state;
      oc = {ifa.pc_write, ifa.pc_write_cond, ifa.ir_write, ifa.i_or_d, ifa.mem_read,
            ifa.mem_write, ifa.mem_2_reg, ifa.reg_dst, ifa.reg_write, ifa.alu_src_a,
            ifa.alu_src_b, ifa.alu_op, ifa.pc_source, ifa.instr_done, ifa.illegal_op};
    end else begin
      os = ifb.state;
      oc = {ifb.pc_write, ifb.pc_write_cond, ifb.ir_write, ifb.i_or_d, ifb.mem_read,
            ifb.mem_write, ifb.mem_2_reg, ifb.reg_dst, ifb.reg_write, ifb.alu_src_a,
            ifb.alu_src_b, ifb.alu_op, ifb.pc_source, ifb.instr_done, ifb.illegal_op};
    end
    cyc_n++;
    check($sformatf("dut%0d state cyc%0d", sel, cyc_n), 32'(os), 32'(g.st));
    check($sformatf("dut%0d ctl cyc%0d", sel, cyc_n), 32'(oc), 32'(g.ctl));
    n_irw  += int'(oc[15]);
    n_done += int'(oc[1]);
    n_mw   += int'(oc[12]);
    if (oc[14] && oc[13]) n_mrd++;
    if (oc[9] && oc[11]) n_m2r++;
    if (oc[17] || oc[16] || oc[15] || oc[12] || oc[9]) n_wr++;
    if (oc[1]) done_at = cyc_n;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.opcode = '0; ifa.zero = 1'b0; ifa.mem_ready = 1'b1;
    ifb.opcode = '0; ifb.zero = 1'b0; ifb.mem_ready = 1'b0;
    @(posedge clk); #1;

    // Power-up reset
    clr();
    cyc(0, 1, 6'h00, 1, 0, S_FETCH);
    cyc(0, 1, 6'h00, 1, 0, S_FETCH);

    // R-type; mem_ready low in DECODE/EXEC_R must not matter
    clr();
    cyc(0, 0, OP_RTYPE, 1, 0, S_FETCH);
    cyc(0, 0, OP_RTYPE, 0, 0, S_DECODE);
    cyc(0, 0, OP_RTYPE, 0, 0, S_EXEC_R);
    cyc(0, 0, OP_RTYPE, 1, 0, S_R_WB);
    check("r_done_cycle", 32'(done_at), 32'd4);

    // LW with 2 fetch and 3 read wait states; opcode port scribbled after DECODE
    clr();
    cyc(0, 0, OP_LW, 0, 0, S_FETCH);
    cyc(0, 0, OP_LW, 0, 0, S_FETCH);
    cyc(0, 0, OP_LW, 1, 0, S_FETCH);
    cyc(0, 0, OP_LW, 1, 0, S_DECODE);
    cyc(0, 0, OP_SW, 1, 0, S_MEM_ADDR);
    cyc(0, 0, OP_J,  0, 0, S_MEM_RD);
    cyc(0, 0, OP_J,  0, 0, S_MEM_RD);
    cyc(0, 0, OP_J,  0, 0, S_MEM_RD);
    cyc(0, 0, OP_J,  1, 0, S_MEM_RD);
    cyc(0, 0, OP_J,  1, 0, S_MEM_WB);
    check("lw_done_cycle", 32'(done_at), 32'd10);
    check("lw_ir_write", 32'(n_irw), 32'd1);
    check("lw_mem_rd_data", 32'(n_mrd), 32'd4);
    check("lw_reg_wr_m2r", 32'(n_m2r), 32'd1);

    // SW then BEQ
    clr();
    cyc(0, 0, OP_SW, 1, 0, S_FETCH);
    cyc(0, 0, OP_SW, 1, 0, S_DECODE);
    cyc(0, 0, OP_SW, 1, 0, S_MEM_ADDR);
    cyc(0, 0, OP_SW, 1, 0, S_MEM_WR);
    check("sw_mem_write", 32'(n_mw), 32'd1);
    check("sw_done_cycle", 32'(done_at), 32'd4);
    clr();
    cyc(0, 0, OP_BEQ, 1, 1, S_FETCH);
    cyc(0, 0, OP_BEQ, 1, 1, S_DECODE);
    cyc(0, 0, OP_BEQ, 1, 1, S_BRANCH);
    check("beq_done_cycle", 32'(done_at), 32'd3);

    // Illegal opcode, then J
    cyc(0, 0, 6'h3F, 1, 0, S_FETCH);
    clr();
    cyc(0, 0, 6'h3F, 1, 0, S_DECODE);
    check("illegal_no_write", 32'(n_wr), 32'd0);
    check("illegal_no_done", 32'(n_done), 32'd0);
    clr();
    cyc(0, 0, OP_J, 1, 0, S_FETCH);
    cyc(0, 0, OP_J, 1, 0, S_DECODE);
    cyc(0, 0, OP_J, 1, 0, S_JUMP);
    check("j_done_cycle", 32'(done_at), 32'd3);

    // ADDI
    clr();
    cyc(0, 0, OP_ADDI, 1, 0, S_FETCH);
    cyc(0, 0, OP_ADDI, 1, 0, S_DECODE);
    cyc(0, 0, OP_ADDI, 1, 0, S_EXEC_I);
    cyc(0, 0, OP_ADDI, 1, 0, S_I_WB);
    check("addi_done_cycle", 32'(done_at), 32'd4);

    // Reset for 2 cycles while LW waits in MEM_RD
    cyc(0, 0, OP_LW, 1, 0, S_FETCH);
    cyc(0, 0, OP_LW, 1, 0, S_DECODE);
    cyc(0, 0, OP_LW, 1, 0, S_MEM_ADDR);
    cyc(0, 0, OP_LW, 0, 0, S_MEM_RD);
    clr();
    cyc(0, 1, OP_LW, 1, 0, S_FETCH);
    cyc(0, 1, OP_LW, 1, 0, S_FETCH);
    check("rst_no_done", 32'(n_done), 32'd0);
    check("rst_no_write", 32'(n_wr), 32'd0);
    cyc(0, 0, OP_RTYPE, 1, 0, S_FETCH);
    cyc(0, 0, OP_RTYPE, 1, 0, S_DECODE);
    cyc(0, 0, OP_RTYPE, 1, 0, S_EXEC_R);
    cyc(0, 0, OP_RTYPE, 1, 0, S_R_WB);

    // No handshake, mem_ready tied low: LW in 5 cycles, later opcode changes ignored
    rst_a = 1'b1;
    clr();
    cyc(1, 1, 6'h00, 0, 0, S_FETCH);
    clr();
    cyc(1, 0, OP_LW,    0, 0, S_FETCH);
    cyc(1, 0, OP_LW,    0, 0, S_DECODE);
    cyc(1, 0, OP_SW,    0, 0, S_MEM_ADDR);
    cyc(1, 0, OP_RTYPE, 0, 0, S_MEM_RD);
    cyc(1, 0, OP_BEQ,   0, 0, S_MEM_WB);
    check("nohs_lw_done_cycle", 32'(done_at), 32'd5);
    check("nohs_lw_reg_wr_m2r", 32'(n_m2r), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
